// File: rtl/vgacon_term_ctrl.sv
// rtl/vgacon_term_ctrl.sv - text console controller: char FIFO, cursor, scroll and clear sequencer
module vgacon_term_ctrl #(
    parameter int NUM_ROWS   = 3,
    parameter int NUM_COLS   = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tty_valid,
    input  logic [8:0] tty_data,
    output logic       tty_ready,
    input  logic       cmd_clear,
    output logic       busy,
    output logic [4:0] cursor,
    output logic       buf_we,
    output logic [4:0] buf_addr,
    output logic [8:0] buf_wdata,
    output logic [4:0] buf_raddr,
    input  logic [8:0] buf_rdata
);

    localparam int N  = NUM_ROWS * NUM_COLS;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [4:0] COLS5       = 5'(NUM_COLS);
    localparam logic [4:0] LAST_ROW    = 5'(NUM_ROWS - 1);
    localparam logic [4:0] LAST_COL    = 5'(NUM_COLS - 1);
    localparam logic [4:0] LAST_CELL   = 5'(N - 1);
    localparam logic [4:0] COPY_LAST   = 5'(N - NUM_COLS - 1);
    localparam logic [4:0] TAIL_FIRST  = 5'(N - NUM_COLS);
    localparam logic [PW:0] FIFO_FULL  = (PW + 1)'(FIFO_DEPTH);
    localparam logic [8:0] BLANK       = 9'h020;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_SCROLL,
        ST_CLEAR
    } state_t;

    state_t      state;
    logic [4:0]  row_q;
    logic [4:0]  col_q;
    logic [4:0]  idx_q;
    logic [8:0]  char_q;
    logic        clr_pend;

    logic [8:0]  fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [PW:0]   count;
    logic        fifo_push;
    logic        fifo_pop;
    logic        fifo_empty;

    logic [6:0]  ascii;
    logic        is_print;

    assign fifo_empty = (count == '0);
    assign tty_ready  = (count != FIFO_FULL);
    assign fifo_push  = tty_valid & tty_ready;
    // A pending clear outranks the FIFO, so the pop is gated the same way as the IDLE branch.
    assign fifo_pop   = (state == ST_IDLE) && !clr_pend && !fifo_empty;

    assign ascii    = char_q[6:0];
    assign is_print = (ascii >= 7'h20) && (ascii <= 7'h7E);
    assign cursor   = row_q * COLS5 + col_q;
    assign busy     = !fifo_empty || clr_pend || (state != ST_IDLE);

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_mem[wptr] <= tty_data;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (fifo_push) wptr <= wptr + PW'(1);
            if (fifo_pop)  rptr <= rptr + PW'(1);
            case ({fifo_push, fifo_pop})
                2'b10:   count <= count + (PW + 1)'(1);
                2'b01:   count <= count - (PW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Console sequencer: command decode, cursor tracking, scroll copy and blanking sweeps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            row_q    <= '0;
            col_q    <= '0;
            idx_q    <= '0;
            char_q   <= '0;
            clr_pend <= 1'b1;
        end else begin
            if (cmd_clear) clr_pend <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (clr_pend) begin
                        state    <= ST_CLEAR;
                        idx_q    <= '0;
                        row_q    <= '0;
                        col_q    <= '0;
                        clr_pend <= cmd_clear;
                    end else if (!fifo_empty) begin
                        char_q <= fifo_mem[rptr];
                        state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    state <= ST_IDLE;
                    if (is_print) begin
                        if (col_q == LAST_COL) begin
                            col_q <= '0;
                            if (row_q == LAST_ROW) begin
                                state <= ST_SCROLL;
                                idx_q <= '0;
                            end else begin
                                row_q <= row_q + 5'd1;
                            end
                        end else begin
                            col_q <= col_q + 5'd1;
                        end
                    end else begin
                        case (ascii)
                            7'h0D: col_q <= '0;
                            7'h0A: begin
                                col_q <= '0;
                                if (row_q == LAST_ROW) begin
                                    state <= ST_SCROLL;
                                    idx_q <= '0;
                                end else begin
                                    row_q <= row_q + 5'd1;
                                end
                            end
                            7'h08: begin
                                if (col_q != '0) col_q <= col_q - 5'd1;
                            end
                            7'h0C: begin
                                state <= ST_CLEAR;
                                idx_q <= '0;
                                row_q <= '0;
                                col_q <= '0;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_SCROLL: begin
                    if (idx_q == COPY_LAST) begin
                        state <= ST_CLEAR;
                        idx_q <= TAIL_FIRST;
                    end else begin
                        idx_q <= idx_q + 5'd1;
                    end
                end
                ST_CLEAR: begin
                    if (idx_q == LAST_CELL) begin
                        state <= ST_IDLE;
                    end else begin
                        idx_q <= idx_q + 5'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Text-buffer port decode from the registered state; quiet in IDLE.
    always_comb begin
        buf_we    = 1'b0;
        buf_addr  = '0;
        buf_raddr = '0;
        buf_wdata = '0;
        case (state)
            ST_EXEC: begin
                if (is_print) begin
                    buf_we    = 1'b1;
                    buf_addr  = cursor;
                    buf_wdata = char_q;
                end else if ((ascii == 7'h08) && (col_q != '0)) begin
                    buf_we    = 1'b1;
                    buf_addr  = cursor - 5'd1;
                    buf_wdata = BLANK;
                end
            end
            ST_SCROLL: begin
                buf_we    = 1'b1;
                buf_addr  = idx_q;
                buf_raddr = idx_q + COLS5;
                buf_wdata = buf_rdata;
            end
            ST_CLEAR: begin
                buf_we    = 1'b1;
                buf_addr  = idx_q;
                buf_wdata = BLANK;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_vgacon_term_ctrl.sv
// tb/tb_vgacon_term_ctrl.sv - directed self-checking bench for vgacon_term_ctrl
module tb_vgacon_term_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tty_valid = 1'b0;
    logic [8:0] tty_data = '0;
    logic       cmd_clear = 1'b0;
    logic       tty_ready;
    logic       busy;
    logic [4:0] cursor;
    logic       buf_we;
    logic [4:0] buf_addr;
    logic [8:0] buf_wdata;
    logic [4:0] buf_raddr;
    logic [8:0] buf_rdata;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int stall_at;
    int t_acc[$];
    int wa[$];
    int wd[$];
    int wc[$];
    logic [8:0] vmem [0:31];

    vgacon_term_ctrl #(.NUM_ROWS(3), .NUM_COLS(10), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .tty_valid(tty_valid), .tty_data(tty_data),
        .tty_ready(tty_ready), .cmd_clear(cmd_clear), .busy(busy), .cursor(cursor),
        .buf_we(buf_we), .buf_addr(buf_addr), .buf_wdata(buf_wdata),
        .buf_raddr(buf_raddr), .buf_rdata(buf_rdata)
    );

    always #5 clk = ~clk;

    assign buf_rdata = vmem[buf_raddr];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (buf_we) begin
            vmem[buf_addr] <= buf_wdata;
            wa.push_back(int'(buf_addr));
            wd.push_back(int'(buf_wdata));
            wc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int ga(int i);
        return (i < wa.size()) ? wa[i] : -1;
    endfunction
    function automatic int gd(int i);
        return (i < wd.size()) ? wd[i] : -1;
    endfunction
    function automatic int gc(int i);
        return (i < wc.size()) ? wc[i] : -1;
    endfunction

    task automatic chk_wr(input int i, input int a, input int d);
        check($sformatf("waddr[%0d]", i), ga(i), a);
        check($sformatf("wdata[%0d]", i), gd(i), d);
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
        wc.delete();
    endtask

    task automatic wait_idle(input int maxc);
        int n = 0;
        @(negedge clk);
        while (busy && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", busy, 0);
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        cmd_clear = 1'b1;
        @(negedge clk);
        cmd_clear = 1'b0;
    endtask

    // Streams characters with tty_valid held high across back-to-back transfers.
    task automatic send_q(input logic [8:0] q[$]);
        stall_at = -1;
        t_acc.delete();
        for (int i = 0; i < q.size(); i++) begin
            int n = 0;
            @(negedge clk);
            tty_valid = 1'b1;
            tty_data  = q[i];
            while (!tty_ready && n < 200) begin
                if (stall_at < 0) stall_at = i;
                @(negedge clk);
                n++;
            end
            check("send_ready", tty_ready, 1);
            t_acc.push_back(cyc);
            @(posedge clk);
        end
        @(negedge clk);
        tty_valid = 1'b0;
    endtask

    task automatic send1(input logic [8:0] c);
        logic [8:0] q[$];
        q.push_back(c);
        send_q(q);
    endtask

    initial begin
        logic [8:0] q[$];
        logic [8:0] c [0:31];
        int n;
        for (int i = 0; i < 32; i++) vmem[i] = '0;

        // Reset values, then the automatic full clear after release.
        repeat (3) @(negedge clk);
        check("rst_ready", tty_ready, 1);
        check("rst_we", buf_we, 0);
        check("rst_cursor", cursor, 0);
        check("rst_busy", busy, 1);
        check("rst_addr", buf_addr, 0);
        check("rst_raddr", buf_raddr, 0);
        check("rst_wdata", buf_wdata, 0);
        rst_n = 1'b1;
        wait_idle(100);
        check("clr0_count", wa.size(), 30);
        for (int i = 0; i < 30; i++) chk_wr(i, i, 9'h020);
        check("clr0_span", gc(29) - gc(0), 29);
        check("clr0_cursor", cursor, 0);

        // Single coloured 'A': write two cycles after acceptance.
        clear_log();
        send1(9'h0C1);
        wait_idle(50);
        check("a_count", wa.size(), 1);
        chk_wr(0, 0, 9'h0C1);
        check("a_latency", gc(0) - t_acc[0], 2);
        check("a_cursor", cursor, 1);

        // Fill the screen, overflow into a scroll, then 'Z'.
        pulse_clear();
        wait_idle(100);
        check("clr1_cursor", cursor, 0);
        clear_log();
        q.delete();
        for (int i = 0; i < 30; i++) begin
            c[i] = {2'(i), 7'(7'h41 + i)};
            q.push_back(c[i]);
        end
        q.push_back(9'h05A);
        send_q(q);
        wait_idle(300);
        check("scr_count", wa.size(), 61);
        for (int i = 0; i < 30; i++) chk_wr(i, i, int'(c[i]));
        for (int i = 0; i < 20; i++) chk_wr(30 + i, i, int'(c[i + 10]));
        for (int i = 0; i < 10; i++) chk_wr(50 + i, 20 + i, 9'h020);
        chk_wr(60, 20, 9'h05A);
        check("scr_cost", gc(59) - gc(30), 29);
        check("scr_cursor", cursor, 21);

        // Back-pressure while a clear runs.
        clear_log();
        pulse_clear();
        q.delete();
        for (int i = 0; i < 6; i++) begin
            c[i] = {2'(i + 1), 7'(7'h61 + i)};
            q.push_back(c[i]);
        end
        send_q(q);
        check("bp_stall_at", stall_at, 4);
        check("bp_reready", t_acc[4] - gc(29), 2);
        wait_idle(100);
        check("bp_count", wa.size(), 36);
        for (int i = 0; i < 30; i++) chk_wr(i, i, 9'h020);
        for (int i = 0; i < 6; i++) chk_wr(30 + i, i, int'(c[i]));
        check("bp_cursor", cursor, 6);

        // Control codes: BS, CR, LF, BS at column 0, unknown code, FF.
        q.delete();
        for (int i = 0; i < 9; i++) q.push_back(9'h061);
        send_q(q);
        wait_idle(100);
        check("cc_cursor15", cursor, 15);
        clear_log();
        send1(9'h008);
        wait_idle(20);
        check("bs_count", wa.size(), 1);
        chk_wr(0, 14, 9'h020);
        check("bs_cursor", cursor, 14);
        send1(9'h00D);
        wait_idle(20);
        check("cr_cursor", cursor, 10);
        send1(9'h00A);
        wait_idle(20);
        check("lf_cursor", cursor, 20);
        send1(9'h008);
        wait_idle(20);
        check("bs0_cursor", cursor, 20);
        send1(9'h181);
        wait_idle(20);
        check("oth_cursor", cursor, 20);
        check("cc_count", wa.size(), 1);
        send1(9'h00C);
        wait_idle(100);
        check("ff_count", wa.size(), 31);
        chk_wr(1, 0, 9'h020);
        chk_wr(30, 29, 9'h020);
        check("ff_cursor", cursor, 0);

        // cmd_clear during a scroll: scroll finishes, full clear, queued chars after.
        clear_log();
        q.delete();
        for (int i = 0; i < 30; i++) begin
            c[i] = {2'(i + 2), 7'(7'h30 + i)};
            q.push_back(c[i]);
        end
        send_q(q);
        n = 0;
        while (wa.size() < 35 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("mid_reach", wa.size() >= 35, 1);
        pulse_clear();
        q.delete();
        q.push_back(9'h078);
        q.push_back(9'h079);
        send_q(q);
        wait_idle(400);
        check("mid_count", wa.size(), 92);
        for (int i = 0; i < 30; i++) chk_wr(i, i, int'(c[i]));
        for (int i = 0; i < 20; i++) chk_wr(30 + i, i, int'(c[i + 10]));
        for (int i = 0; i < 10; i++) chk_wr(50 + i, 20 + i, 9'h020);
        for (int i = 0; i < 30; i++) chk_wr(60 + i, i, 9'h020);
        chk_wr(90, 0, 9'h078);
        chk_wr(91, 1, 9'h079);
        check("mid_cursor", cursor, 2);

        // Reset in the middle of a clear stops writes at once.
        pulse_clear();
        repeat (5) @(negedge clk);
        n = wa.size();
        rst_n = 1'b0;
        #1;
        check("abort_we", buf_we, 0);
        repeat (3) @(negedge clk);
        check("abort_nowr", wa.size(), n);
        check("abort_cursor", cursor, 0);
        check("abort_busy", busy, 1);
        clear_log();
        rst_n = 1'b1;
        wait_idle(100);
        check("rclr_count", wa.size(), 30);
        chk_wr(0, 0, 9'h020);
        chk_wr(29, 29, 9'h020);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
